datapath_bus_arbiter: RTL and testbench
=======================================

# datapath_bus_arbiter

Parametrised successor to the datapath's single-driver bus multiplexer. It selects one of NSRC source registers onto the shared datapath bus from per-source out-enable strobes, with two selection modes: fixed priority or round-robin. It adds the following:
- a bus keeper that holds the last driven value when no source is enabled;
- a registered ownership record;
- sticky multi-driver contention detection with a saturating event counter that control-unit debug logic can read.

## Interface
Parameters:
- WIDTH, 32, data width of each source and of the bus.
- NSRC, 24, number of sources; legal range 2..64.
- MODE, 0, arbitration when several enables are set: 0 = fixed priority (lowest index wins), 1 = round-robin.
- CNT_W, 8, width of the contention counter.

Ports (IDX_W = $clog2(NSRC)):
- clock  in  1  rising-edge clock for all state.
- clear  in  1  reset, asynchronous and active-low; state is reset while clear = 0.
- out_en  in  NSRC  per-source drive strobes; bit i corresponds to R0out..Cout order.
- src_data  in  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- clr_err  in  1  synchronous clear of the contention status and counter.
- bus_out  out  WIDTH  bus value, combinational from inputs and keeper.
- bus_q  out  WIDTH  bus value registered one cycle later.
- owner  out  IDX_W  index of the last winning source, registered.
- owner_valid  out  1  high once any source has driven since reset.
- conflict  out  1  combinational; high when more than one out_en bit is set.
- conflict_sticky  out  1  registered; set by any conflict, cleared by clr_err.
- conflict_cnt  out  CNT_W  registered count of conflict cycles, saturating.

## Operation
- Winner selection (combinational):
  - out_en == 0: no winner.
  - MODE 0: the lowest set index wins.
  - MODE 1: the first set index strictly after the registered owner wins. The search is cyclic, wrapping from NSRC-1 to 0. If only the owner's own bit is set, the owner wins again.
- bus_out:
  - When a winner exists, bus_out equals that winner's source slice.
  - Otherwise bus_out equals the keeper register.
  - The bus is never X and never zero by default after its first drive.
- Each clock edge with a winner: keeper <= winning data, owner <= winner index, owner_valid <= 1.
- Each clock edge with no winner: keeper, owner and owner_valid hold their values.
- bus_q <= bus_out on every clock edge.
- Contention handling:
  - conflict = (popcount(out_en) > 1).
  - On an edge with conflict = 1: conflict_sticky <= 1, and conflict_cnt increments, saturating at 2^CNT_W-1.
- clr_err handling:
  - On an edge with clr_err = 1 and conflict = 0: sticky <= 0, cnt <= 0.
  - On an edge with clr_err = 1 and conflict = 1: sticky <= 1, cnt <= 1. The new event wins over the clear.
- Reset values (clear = 0, asynchronous):
  - keeper = 0, bus_q = 0.
  - owner = NSRC-1, so the first round-robin grant starts search at index 0.
  - owner_valid = 0, conflict_sticky = 0, conflict_cnt = 0.
  - bus_out therefore reads 0 while no source is enabled.
- Out-of-range behaviour: any out_en bit at index NSRC or above does not exist, so no out-of-range behaviour is defined.

## Timing
- Source to bus_out: zero cycles, a combinational path. The datapath depends on same-cycle drive-and-latch.
- bus_q, owner, keeper and status outputs: one cycle after the driving edge.
- Round-robin fairness: with k enables held continuously, each of them wins exactly once every k cycles.
- Changing MODE requires re-elaboration; MODE is not a runtime input.
- Reset mid-operation:
  - All registered outputs go to their reset values immediately, with no clock edge required.
  - bus_out may still show a live source during reset, because it is combinational.
  - The first edge after clear rises behaves as an edge from the reset state.
- Saturation: conflict_cnt stays at 255 (CNT_W = 8) under further conflicts until clr_err or reset.

## Test plan
- Reset then idle:
  - Stimulus: clear = 0 with out_en = 0, then release clear and run 3 cycles.
  - Required: bus_out = 0, bus_q = 0, owner = 23, owner_valid = 0.
- Single drive and keeper:
  - Stimulus: R5 = 0xDEADBEEF with out_en[5] = 1 for one cycle, then out_en = 0.
  - Required: bus_out = 0xDEADBEEF in both cycles; owner = 5 and bus_q = 0xDEADBEEF one cycle later.
- MODE 0 priority under conflict:
  - Stimulus: out_en bits 3 and 9 set, with R3 = 0x3 and R9 = 0x9.
  - Required: bus_out = 0x3 and conflict = 1; after the edge, conflict_sticky = 1 and conflict_cnt = 1.
- MODE 1 round-robin:
  - Stimulus: from reset, hold out_en bits 2, 7 and 20 for 6 cycles.
  - Required: winners 2, 7, 20, 2, 7, 20; conflict_cnt = 6.
- Saturation and clear:
  - Stimulus: hold a conflict for 300 cycles; then assert clr_err alone; then assert clr_err together with a conflict.
  - Required: conflict_cnt = 255 after the conflict run; sticky = 0 and cnt = 0 after the lone clr_err; sticky = 1 and cnt = 1 after the combined clr_err and conflict.
- Asynchronous reset mid-stream:
  - Stimulus: drop clear between edges while owner = 7 and the keeper holds a value.
  - Required: owner = 23, keeper = 0 and conflict_cnt = 0 before the next clock edge.

Source files
------------

// File: rtl/datapath_bus_arbiter.sv
// Shared datapath bus driver: picks one of NSRC sources from out-enable strobes,
// keeps the last driven value when idle, and records ownership and contention.

module datapath_bus_arbiter_slot #(
  parameter int WIDTH = 32
) (
  input  logic             gnt_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);
  assign data_o = {WIDTH{gnt_i}} & data_i;
endmodule

module datapath_bus_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NSRC  = 24,
  parameter  int MODE  = 0,
  parameter  int CNT_W = 8,
  localparam int IDX_W = $clog2(NSRC)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NSRC-1:0]       out_en,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      bus_out,
  output logic [WIDTH-1:0]      bus_q,
  output logic [IDX_W-1:0]      owner,
  output logic                  owner_valid,
  output logic                  conflict,
  output logic                  conflict_sticky,
  output logic [CNT_W-1:0]      conflict_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0]            keeper_q, busq_q;
  logic [IDX_W-1:0]            owner_q;
  logic                        ownv_q, sticky_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        sticky_d;
  logic                        win_vld;
  logic [IDX_W-1:0]            win_idx;
  logic [NSRC-1:0]             gnt;
  logic [NSRC-1:0][WIDTH-1:0]  slot_data;
  logic [WIDTH-1:0]            sel_data;

  // Lowest set index (MODE 0) or first set index cyclically after the owner (MODE 1).
  // Loops run from the far end so the nearest candidate is the last assignment.
  always_comb begin
    int j;
    j       = 0;
    win_vld = |out_en;
    win_idx = '0;
    if (MODE == 0) begin
      for (int i = NSRC - 1; i >= 0; i--)
        if (out_en[i]) win_idx = IDX_W'(i);
    end else begin
      for (int k = NSRC; k >= 1; k--) begin
        j = (int'(owner_q) + k) % NSRC;
        if (out_en[j]) win_idx = IDX_W'(j);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_slot
      assign gnt[g] = win_vld && (win_idx == IDX_W'(g));
      datapath_bus_arbiter_slot #(.WIDTH(WIDTH)) u_slot (
        .gnt_i  (gnt[g]),
        .data_i (src_data[g*WIDTH +: WIDTH]),
        .data_o (slot_data[g])
      );
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NSRC; i++) sel_data = sel_data | slot_data[i];
  end

  assign bus_out  = win_vld ? sel_data : keeper_q;
  assign conflict = (out_en & (out_en - 1'b1)) != '0;

  // A conflict in the same cycle as clr_err counts as a fresh first event.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (conflict) begin
      sticky_d = 1'b1;
      if (clr_err)              cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      keeper_q <= '0;
      busq_q   <= '0;
      owner_q  <= IDX_W'(NSRC - 1);
      ownv_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      busq_q   <= bus_out;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      if (win_vld) begin
        keeper_q <= sel_data;
        owner_q  <= win_idx;
        ownv_q   <= 1'b1;
      end
    end
  end

  assign bus_q           = busq_q;
  assign owner           = owner_q;
  assign owner_valid     = ownv_q;
  assign conflict_sticky = sticky_q;
  assign conflict_cnt    = cnt_q;
endmodule

// File: tb/tb_datapath_bus_arbiter.sv
// Scoreboard bench for datapath_bus_arbiter: one fixed-priority and one round-robin
// instance share stimulus; a reference model queues per-cycle expectations.

module tb_datapath_bus_arbiter;
  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int CNT_W = 8;
  localparam int IDX_W = $clog2(NSRC);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                  clock = 1'b0;
  logic                  clear = 1'b0;
  logic [NSRC-1:0]       out_en = '0;
  logic [NSRC*WIDTH-1:0] src_data = '0;
  logic                  clr_err = 1'b0;

  logic [WIDTH-1:0] bus_out0, bus_out1, bus_q0, bus_q1;
  logic [IDX_W-1:0] owner0, owner1;
  logic             ov0, ov1, conf0, conf1, stk0, stk1;
  logic [CNT_W-1:0] cnt0, cnt1;

  always #5 clock = ~clock;

  datapath_bus_arbiter #(.WIDTH(WIDTH), .NSRC(NSRC), .MODE(0), .CNT_W(CNT_W)) dut0 (
    .clock(clock), .clear(clear), .out_en(out_en), .src_data(src_data), .clr_err(clr_err),
    .bus_out(bus_out0), .bus_q(bus_q0), .owner(owner0), .owner_valid(ov0),
    .conflict(conf0), .conflict_sticky(stk0), .conflict_cnt(cnt0));

  datapath_bus_arbiter #(.WIDTH(WIDTH), .NSRC(NSRC), .MODE(1), .CNT_W(CNT_W)) dut1 (
    .clock(clock), .clear(clear), .out_en(out_en), .src_data(src_data), .clr_err(clr_err),
    .bus_out(bus_out1), .bus_q(bus_q1), .owner(owner1), .owner_valid(ov1),
    .conflict(conf1), .conflict_sticky(stk1), .conflict_cnt(cnt1));

  typedef struct {
    logic [WIDTH-1:0] bus [2];
    logic [WIDTH-1:0] busq [2];
    int               own [2];
    bit               ov [2];
    bit               conf;
    bit               sticky;
    int               cnt;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;

  // Reference state, one copy per arbitration mode where it differs.
  logic [WIDTH-1:0] m_kp [2];
  logic [WIDTH-1:0] m_bq [2];
  int               m_own [2];
  bit               m_ov [2];
  bit               m_stk;
  int               m_cnt;
  logic [WIDTH-1:0] src [NSRC];

  function automatic int winner(input logic [NSRC-1:0] en, input int mode, input int own);
    if (mode == 0) begin
      for (int i = 0; i < NSRC; i++) if (en[i]) return i;
    end else begin
      for (int k = 1; k <= NSRC; k++) if (en[(own + k) % NSRC]) return (own + k) % NSRC;
    end
    return -1;
  endfunction

  function automatic logic [NSRC-1:0] bit_at(input int i);
    logic [NSRC-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_kp[m] = '0; m_bq[m] = '0; m_own[m] = NSRC - 1; m_ov[m] = 1'b0;
    end
    m_stk = 1'b0;
    m_cnt = 0;
  endtask

  task automatic rnd_src();
    for (int i = 0; i < NSRC; i++) src[i] = $urandom;
  endtask

  // Drive one cycle between edges, queue what the outputs must show before the next
  // edge, then advance the model through that edge.
  task automatic cyc(input logic [NSRC-1:0] en, input bit ce, input bit cn);
    exp_t e;
    int   w [2];
    bit   cf;
    @(posedge clock);
    #1;
    for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = src[i];
    out_en  = en;
    clr_err = ce;
    clear   = cn;
    if (!cn) model_reset();
    cf = $countones(en) > 1;
    for (int m = 0; m < 2; m++) begin
      w[m]      = winner(en, m, m_own[m]);
      e.bus[m]  = (w[m] >= 0) ? src[w[m]] : m_kp[m];
      e.busq[m] = m_bq[m];
      e.own[m]  = m_own[m];
      e.ov[m]   = m_ov[m];
    end
    e.conf   = cf;
    e.sticky = m_stk;
    e.cnt    = m_cnt;
    exp_q.push_back(e);
    if (cn) begin
      for (int m = 0; m < 2; m++) begin
        m_bq[m] = e.bus[m];
        if (w[m] >= 0) begin
          m_kp[m] = src[w[m]]; m_own[m] = w[m]; m_ov[m] = 1'b1;
        end
      end
      if (cf) begin
        m_stk = 1'b1;
        m_cnt = ce ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
      end else if (ce) begin
        m_stk = 1'b0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("bus_out_m0", 64'(bus_out0), 64'(e.bus[0]));
      chk("bus_out_m1", 64'(bus_out1), 64'(e.bus[1]));
      chk("bus_q_m0",   64'(bus_q0),   64'(e.busq[0]));
      chk("bus_q_m1",   64'(bus_q1),   64'(e.busq[1]));
      chk("owner_m0",   64'(owner0),   64'(e.own[0]));
      chk("owner_m1",   64'(owner1),   64'(e.own[1]));
      chk("owner_valid_m0", 64'(ov0), 64'(e.ov[0]));
      chk("owner_valid_m1", 64'(ov1), 64'(e.ov[1]));
      chk("conflict_m0", 64'(conf0), 64'(e.conf));
      chk("conflict_m1", 64'(conf1), 64'(e.conf));
      chk("sticky_m0", 64'(stk0), 64'(e.sticky));
      chk("sticky_m1", 64'(stk1), 64'(e.sticky));
      chk("cnt_m0", 64'(cnt0), 64'(e.cnt));
      chk("cnt_m1", 64'(cnt1), 64'(e.cnt));
    end
  end

  initial begin
    logic [NSRC-1:0] en;
    model_reset();
    rnd_src();
    // Reset then idle.
    cyc('0, 0, 0);
    cyc('0, 0, 0);
    repeat (3) cyc('0, 0, 1);
    // Single drive then keeper hold.
    rnd_src(); src[5] = 32'hDEADBEEF;
    cyc(bit_at(5), 0, 1);
    rnd_src();
    cyc('0, 0, 1);
    cyc('0, 0, 1);
    // Two-way conflict.
    rnd_src(); src[3] = 32'h3; src[9] = 32'h9;
    cyc(bit_at(3) | bit_at(9), 0, 1);
    cyc('0, 0, 1);
    // Round-robin rotation from reset.
    cyc('0, 0, 0);
    cyc('0, 0, 1);
    repeat (6) begin
      rnd_src();
      cyc(bit_at(2) | bit_at(7) | bit_at(20), 0, 1);
    end
    cyc('0, 0, 1);
    // Saturation, lone clear, clear coinciding with a conflict.
    repeat (300) begin
      rnd_src();
      cyc(bit_at(0) | bit_at(13), 0, 1);
    end
    cyc('0, 1, 1);
    cyc(bit_at(1) | bit_at(4), 1, 1);
    cyc('0, 0, 1);
    // Random traffic.
    repeat (400) begin
      rnd_src();
      case ($urandom_range(0, 3))
        0: en = '0;
        1: en = bit_at($urandom_range(0, NSRC - 1));
        2: en = bit_at($urandom_range(0, NSRC - 1)) | bit_at($urandom_range(0, NSRC - 1));
        default: en = NSRC'($urandom);
      endcase
      cyc(en, ($urandom_range(0, 7) == 0), 1);
    end
    // Asynchronous reset between edges with owner 7 and a held keeper.
    rnd_src();
    cyc(bit_at(7), 0, 1);
    cyc('0, 0, 1);
    cyc('0, 0, 0);
    cyc('0, 0, 1);
    cyc('0, 0, 1);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      nchk++; nerr++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
